// File: rtl/mmio_io_ctrl_pkg.sv
// mmio_io_ctrl_pkg: bus command encoding and default address map for the MMIO block
package mmio_io_ctrl_pkg;
  typedef enum logic [1:0] {MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10} mem_cmd_e;
  localparam logic [8:0] DEF_IN_BASE  = 9'h140;
  localparam logic [8:0] DEF_OUT_BASE = 9'h100;
  function automatic logic is_access(logic [1:0] cmd);
    return cmd == MREAD || cmd == MWRITE;
  endfunction
endpackage

// File: rtl/mmio_io_ctrl_if.sv
// mmio_io_ctrl_if: CPU memory bus as seen by the MMIO block
interface mmio_io_ctrl_if #(parameter int DATA_W = 16, parameter int ADDR_W = 9);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic              hit;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  modport master (output mem_cmd, mem_addr, write_data, input hit, read_data, read_valid);
  modport slave (input mem_cmd, mem_addr, write_data, output hit, read_data, read_valid);
endinterface

// File: rtl/mmio_io_ctrl_io_sync2.sv
// io_sync2: two-flop synchroniser for one asynchronous input port
module io_sync2 #(parameter int W = 16) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      meta <= '0;
      q <= '0;
    end else begin
      meta <= d;
      q <= meta;
    end
endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped output registers, synchronised inputs, sticky change flags and irq
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int N_IN = 2,
  parameter int N_OUT = 2,
  parameter logic [ADDR_W-1:0] IN_BASE = ADDR_W'(DEF_IN_BASE),
  parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(DEF_OUT_BASE)
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_io_ctrl_if.slave           bus,
  input  logic [N_IN*DATA_W-1:0]  in_ports,
  output logic [N_OUT*DATA_W-1:0] out_ports,
  output logic                    irq
);
  localparam logic [ADDR_W-1:0] STAT_ADDR = IN_BASE + ADDR_W'(N_IN);
  localparam logic [ADDR_W-1:0] MASK_ADDR = STAT_ADDR + ADDR_W'(1);
  logic [DATA_W-1:0] sync [N_IN];
  logic [DATA_W-1:0] prev [N_IN];
  logic [DATA_W-1:0] outr [N_OUT];
  logic [N_IN-1:0] flags, mask, change;
  logic [ADDR_W-1:0] off_out, off_in;
  logic acc, out_hit, in_hit, stat_hit, mask_hit, rd, wr;
  logic [DATA_W-1:0] rd_val;
  for (genvar j = 0; j < N_IN; j++) begin : g_in
    io_sync2 #(.W(DATA_W)) u_sync (
      .clk(clk),
      .reset(reset),
      .d(in_ports[j*DATA_W +: DATA_W]),
      .q(sync[j])
    );
    assign change[j] = sync[j] != prev[j];
  end
  for (genvar i = 0; i < N_OUT; i++) begin : g_out
    assign out_ports[i*DATA_W +: DATA_W] = outr[i];
  end
  // Offsets wrap below the base, so a single unsigned compare bounds each region.
  assign off_out = bus.mem_addr - OUT_BASE;
  assign off_in = bus.mem_addr - IN_BASE;
  assign acc = is_access(bus.mem_cmd);
  assign out_hit = off_out < ADDR_W'(N_OUT);
  assign in_hit = off_in < ADDR_W'(N_IN);
  assign stat_hit = bus.mem_addr == STAT_ADDR;
  assign mask_hit = bus.mem_addr == MASK_ADDR;
  assign bus.hit = acc && (out_hit || in_hit || stat_hit || mask_hit);
  assign rd = bus.hit && bus.mem_cmd == MREAD;
  assign wr = bus.hit && bus.mem_cmd == MWRITE;
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_OUT; i++) if (out_hit && off_out == ADDR_W'(i)) rd_val = outr[i];
    for (int j = 0; j < N_IN; j++) if (in_hit && off_in == ADDR_W'(j)) rd_val = sync[j];
    if (stat_hit) rd_val = DATA_W'(flags);
    if (mask_hit) rd_val = DATA_W'(mask);
  end
  always_comb if (acc) assert ($countones({out_hit, in_hit, stat_hit, mask_hit}) <= 1);
  // Clear is applied before the OR so a flag that sets on the read edge survives it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev <= '{default: '0};
      outr <= '{default: '0};
      flags <= '0;
      mask <= '0;
      irq <= 1'b0;
      bus.read_data <= '0;
      bus.read_valid <= 1'b0;
    end else begin
      prev <= sync;
      flags <= (flags & ~{N_IN{rd && stat_hit}}) | change;
      irq <= |(flags & mask);
      bus.read_valid <= rd;
      if (rd) bus.read_data <= rd_val;
      if (wr && mask_hit) mask <= bus.write_data[N_IN-1:0];
      for (int i = 0; i < N_OUT; i++) if (wr && out_hit && off_out == ADDR_W'(i)) outr[i] <= bus.write_data;
    end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed and random bus traffic checked against a cycle-level behavioural model
module tb_mmio_io_ctrl;
  localparam int DW = 16, AW = 9, NI = 2, NO = 2;
  localparam logic [1:0] C_NONE = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_BAD = 2'b11;
  logic clk = 1'b0, reset = 1'b1;
  logic [NI*DW-1:0] in_ports = '0;
  logic [NO*DW-1:0] out_ports;
  logic irq;
  int checks = 0, errors = 0;
  mmio_io_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  mmio_io_ctrl #(.DATA_W(DW), .ADDR_W(AW), .N_IN(NI), .N_OUT(NO), .IN_BASE(9'h140), .OUT_BASE(9'h100)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .in_ports(in_ports),
    .out_ports(out_ports),
    .irq(irq)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] m_out [NO];
  logic [NI-1:0] m_mask, m_flags;
  logic m_irq, m_rv;
  logic [DW-1:0] m_rd;
  logic [NI*DW-1:0] hist [3];
  logic [NO*DW-1:0] saved;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    for (int i = 0; i < NO; i++) m_out[i] = '0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    m_mask = '0;
    m_flags = '0;
    m_irq = 1'b0;
    m_rv = 1'b0;
    m_rd = '0;
  endtask
  function automatic bit mapped(int a);
    return (a >= 256 && a < 256 + NO) || (a >= 320 && a < 320 + NI + 2);
  endfunction
  function automatic bit exp_hit(logic [1:0] c, logic [AW-1:0] a);
    return (c == C_RD || c == C_WR) && mapped(int'(a));
  endfunction
  function automatic logic [DW-1:0] port_of(logic [NI*DW-1:0] v, int j);
    return v[j*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] read_model(int a);
    if (a < 320) return m_out[a-256];
    if (a < 320 + NI) return port_of(hist[1], a - 320);
    if (a == 320 + NI) return DW'(m_flags);
    return DW'(m_mask);
  endfunction
  // hist[0..2] hold the in_ports samples from the last three edges; the synchronised value
  // visible to a read is two edges old, and a flag sets when that differs from the one before.
  task automatic model_edge(logic [1:0] c, logic [AW-1:0] a, logic [DW-1:0] wd);
    int ia;
    logic [NI-1:0] chg;
    ia = int'(a);
    for (int j = 0; j < NI; j++) chg[j] = port_of(hist[1], j) != port_of(hist[2], j);
    m_irq = |(m_flags & m_mask);
    m_rv = c == C_RD && mapped(ia);
    if (m_rv) m_rd = read_model(ia);
    if (m_rv && ia == 320 + NI) m_flags = '0;
    m_flags = m_flags | chg;
    if (c == C_WR && ia >= 256 && ia < 256 + NO) m_out[ia-256] = wd;
    if (c == C_WR && ia == 321 + NI) m_mask = wd[NI-1:0];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = in_ports;
  endtask
  task automatic cyc(logic [1:0] c, logic [AW-1:0] a, logic [DW-1:0] wd);
    bus.mem_cmd = c;
    bus.mem_addr = a;
    bus.write_data = wd;
    #1 chk("hit", bus.hit, exp_hit(c, a));
    @(posedge clk);
    model_edge(c, a, wd);
    #1;
    chk("read_valid", bus.read_valid, m_rv);
    chk("read_data", bus.read_data, m_rd);
    chk("irq", irq, m_irq);
    chk("out_ports", out_ports, {m_out[1], m_out[0]});
    @(negedge clk);
  endtask
  initial begin
    logic [1:0] c;
    logic [AW-1:0] a;
    bus.mem_cmd = C_NONE;
    bus.mem_addr = '0;
    bus.write_data = '0;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_out", out_ports, 0);
    chk("rst_rv", bus.read_valid, 0);
    chk("rst_rd", bus.read_data, 0);
    chk("rst_irq", irq, 0);
    cyc(C_WR, 9'h100, 16'h0002);
    chk("wr_out0", out_ports[15:0], 16'h0002);
    cyc(C_RD, 9'h100, 16'h0000);
    chk("rd_out0_v", bus.read_valid, 1);
    chk("rd_out0", bus.read_data, 16'h0002);
    cyc(C_NONE, 9'h100, 16'h0000);
    chk("rv_pulse", bus.read_valid, 0);
    in_ports[15:0] = 16'h0001;
    cyc(C_NONE, 9'h000, 16'h0000);
    cyc(C_NONE, 9'h000, 16'h0000);
    cyc(C_RD, 9'h140, 16'h0000);
    chk("rd_in0", bus.read_data, 16'h0001);
    chk("rd_in0_v", bus.read_valid, 1);
    cyc(C_RD, 9'h142, 16'h0000);
    cyc(C_WR, 9'h143, 16'h0001);
    in_ports[15:0] = 16'h0000;
    repeat (3) cyc(C_NONE, 9'h000, 16'h0000);
    chk("irq_early", irq, 0);
    cyc(C_NONE, 9'h000, 16'h0000);
    chk("irq_set", irq, 1);
    cyc(C_RD, 9'h142, 16'h0000);
    chk("stat_rd", bus.read_data, 16'h0001);
    cyc(C_NONE, 9'h000, 16'h0000);
    chk("irq_clr", irq, 0);
    cyc(C_RD, 9'h142, 16'h0000);
    chk("stat_empty", bus.read_data, 16'h0000);
    in_ports[31:16] = 16'h00a5;
    cyc(C_NONE, 9'h000, 16'h0000);
    cyc(C_NONE, 9'h000, 16'h0000);
    cyc(C_RD, 9'h142, 16'h0000);
    chk("setwin_0", bus.read_data, 16'h0000);
    cyc(C_RD, 9'h142, 16'h0000);
    chk("setwin_1", bus.read_data, 16'h0002);
    saved = out_ports;
    cyc(C_WR, 9'h140, 16'hffff);
    chk("ro_hit", bus.hit, 1);
    cyc(C_RD, 9'h000, 16'h0000);
    chk("unm_hit", bus.hit, 0);
    chk("unm_rv", bus.read_valid, 0);
    cyc(C_WR, 9'h000, 16'h1234);
    cyc(C_BAD, 9'h100, 16'h4321);
    chk("unm_out", out_ports, saved);
    cyc(C_RD, 9'h140, 16'h0000);
    chk("ro_in0", bus.read_data, 16'h0000);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) in_ports = {$urandom(), $urandom()};
      c = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = 9'h100 + 9'($urandom_range(0, 2));
        1: a = 9'h140 + 9'($urandom_range(0, 5));
        2: a = 9'($urandom());
        default: a = 9'h142 + 9'($urandom_range(0, 1));
      endcase
      cyc(c, a, 16'($urandom()));
    end
    cyc(C_WR, 9'h101, 16'h1234);
    cyc(C_RD, 9'h101, 16'h0000);
    bus.mem_cmd = C_WR;
    bus.mem_addr = 9'h100;
    bus.write_data = 16'h5555;
    #2 reset = 1'b1;
    #1;
    chk("arst_out", out_ports, 0);
    chk("arst_rd", bus.read_data, 0);
    chk("arst_rv", bus.read_valid, 0);
    chk("arst_irq", irq, 0);
    @(posedge clk);
    #1;
    chk("arst_nowr", out_ports, 0);
    chk("arst_norv", bus.read_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    cyc(C_RD, 9'h100, 16'h0000);
    chk("post_rst", bus.read_data, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
